// File: rtl/rect_copy_pkg.sv
// Shared types for the rectangle copy DMA stage: controller states, table fields
// and the per-rect word count.
package rect_copy_pkg;

    localparam int RECT_WORDS = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_START  = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } rcc_state_t;

    typedef enum logic [2:0] {
        FIELD_X     = 3'd0,
        FIELD_Y     = 3'd1,
        FIELD_W     = 3'd2,
        FIELD_H     = 3'd3,
        FIELD_COLOR = 3'd4
    } rect_field_t;

    function automatic rect_field_t next_field(input rect_field_t f);
        case (f)
            FIELD_X:     next_field = FIELD_Y;
            FIELD_Y:     next_field = FIELD_W;
            FIELD_W:     next_field = FIELD_H;
            FIELD_H:     next_field = FIELD_COLOR;
            FIELD_COLOR: next_field = FIELD_X;
            default:     next_field = FIELD_X;
        endcase
    endfunction

endpackage

// File: rtl/rect_abs_unit.sv
// Converts the (x, y, w, h, color) read stream into (left, top, right, bottom, color).
// Clipping of right/bottom to the screen is enabled by defining RECT_CLIP_EN.
module rect_abs_unit
    import rect_copy_pkg::*;
#(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_valid,
    input  logic [2:0]  rd_field,
    input  logic [15:0] rdata,
    output logic [15:0] dout
);

`ifdef RECT_CLIP_EN
    localparam logic CLIP_EN = 1'b1;
`else
    localparam logic CLIP_EN = 1'b0;
`endif

    localparam logic [15:0] LIMIT_W = 16'(SCREEN_WIDTH);
    localparam logic [15:0] LIMIT_H = 16'(SCREEN_HEIGHT);

    // 17-bit sum so a carry out of 16 bits always counts as past the clip limit
    function automatic logic [15:0] abs_sum(input logic [15:0] a, input logic [15:0] b,
                                            input logic [15:0] lim);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (CLIP_EN && (s > {1'b0, lim})) begin
            abs_sum = lim;
        end else begin
            abs_sum = s[15:0];
        end
    endfunction

    logic        valid_d_r;
    rect_field_t field_d_r;
    logic [15:0] x_r;
    logic [15:0] y_r;
    logic [15:0] dout_r;
    logic [15:0] word_s;

    // Select the outgoing word by the field of the read whose data is now on rdata
    always_comb begin
        word_s = rdata;
        case (field_d_r)
            FIELD_W: word_s = abs_sum(x_r, rdata, LIMIT_W);
            FIELD_H: word_s = abs_sum(y_r, rdata, LIMIT_H);
            default: word_s = rdata;
        endcase
    end

    // Read-to-data alignment, x/y holders and the output word register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_d_r <= 1'b0;
            field_d_r <= FIELD_X;
            x_r       <= 16'h0000;
            y_r       <= 16'h0000;
            dout_r    <= 16'h0000;
        end else begin
            valid_d_r <= rd_valid;
            field_d_r <= rect_field_t'(rd_field);
            if (valid_d_r) begin
                dout_r <= word_s;
                if (field_d_r == FIELD_X) x_r <= rdata;
                if (field_d_r == FIELD_Y) y_r <= rdata;
            end
        end
    end

    assign dout = dout_r;

endmodule

// File: rtl/rect_copy_controller.sv
// Per-frame DMA of the rectangle table into the GPU word stream.
// Optional clipping of right/bottom is built when RECT_CLIP_EN is defined.
module rect_copy_controller
    import rect_copy_pkg::*;
#(
    parameter int                         RECT_COUNT       = 64,
    parameter int                         RECT_COUNT_WIDTH = 6,
    parameter int                         ADDR_WIDTH       = 16,
    parameter logic [ADDR_WIDTH-1:0]      RECT_MEM_BASE    = 16'h0000,
    parameter int                         SCREEN_WIDTH     = 640,
    parameter int                         SCREEN_HEIGHT    = 480
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    output logic                  mem_req,
    input  logic                  mem_grant,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [15:0]           mem_rdata,
    output logic                  copy_start,
    output logic [15:0]           dout,
    output logic                  busy,
    output logic                  done
);

    localparam logic [RECT_COUNT_WIDTH-1:0] RECT_LAST = RECT_COUNT_WIDTH'(RECT_COUNT - 1);

    rcc_state_t                  state_r;
    rcc_state_t                  nxt_s;
    rect_field_t                 field_r;
    logic [RECT_COUNT_WIDTH-1:0] rect_r;
    logic [ADDR_WIDTH-1:0]       addr_r;
    logic                        drain_r;
    logic                        mem_req_r;
    logic                        mem_rd_r;
    logic                        copy_start_r;
    logic                        busy_r;
    logic                        done_r;
    logic                        last_read_s;

    assign last_read_s = (field_r == FIELD_COLOR) && (rect_r == RECT_LAST);

    // Next-state decode
    always_comb begin
        nxt_s = state_r;
        case (state_r)
            ST_IDLE:   if (frame_start) nxt_s = ST_REQ;    else nxt_s = ST_IDLE;
            ST_REQ:    if (mem_grant)   nxt_s = ST_START;  else nxt_s = ST_REQ;
            ST_START:  nxt_s = ST_STREAM;
            ST_STREAM: if (last_read_s) nxt_s = ST_DRAIN;  else nxt_s = ST_STREAM;
            ST_DRAIN:  if (drain_r)     nxt_s = ST_DONE;   else nxt_s = ST_DRAIN;
            ST_DONE:   nxt_s = ST_IDLE;
            default:   nxt_s = ST_IDLE;
        endcase
    end

    // State register, read counters and address generator
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            field_r <= FIELD_X;
            rect_r  <= '0;
            addr_r  <= RECT_MEM_BASE;
            drain_r <= 1'b0;
        end else begin
            state_r <= nxt_s;
            drain_r <= (state_r == ST_DRAIN) ? ~drain_r : 1'b0;
            if (nxt_s == ST_START) begin
                field_r <= FIELD_X;
                rect_r  <= '0;
                addr_r  <= RECT_MEM_BASE;
            end else if ((state_r == ST_START) || (state_r == ST_STREAM)) begin
                field_r <= next_field(field_r);
                if (field_r == FIELD_COLOR) begin
                    rect_r <= (rect_r == RECT_LAST) ? '0 : rect_r + RECT_COUNT_WIDTH'(1);
                end
                if (nxt_s == ST_STREAM) addr_r <= addr_r + ADDR_WIDTH'(1);
            end
        end
    end

    // Control outputs registered from the next state so they line up with it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req_r    <= 1'b0;
            mem_rd_r     <= 1'b0;
            copy_start_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            mem_req_r    <= (nxt_s == ST_REQ) || (nxt_s == ST_START) || (nxt_s == ST_STREAM);
            mem_rd_r     <= (nxt_s == ST_START) || (nxt_s == ST_STREAM);
            copy_start_r <= (nxt_s == ST_START);
            busy_r       <= (nxt_s != ST_IDLE) && (nxt_s != ST_DONE);
            done_r       <= (nxt_s == ST_DONE);
        end
    end

    rect_abs_unit #(
        .SCREEN_WIDTH  (SCREEN_WIDTH),
        .SCREEN_HEIGHT (SCREEN_HEIGHT)
    ) u_abs (
        .clk      (clk),
        .reset    (reset),
        .rd_valid (mem_rd_r),
        .rd_field (field_r),
        .rdata    (mem_rdata),
        .dout     (dout)
    );

    assign mem_req    = mem_req_r;
    assign mem_rd     = mem_rd_r;
    assign mem_addr   = addr_r;
    assign copy_start = copy_start_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule
